// File: rtl/pipeline_mem_access_pkg.sv
// pipeline_mem_access_pkg: shared types and constants for the MEM-stage bus controller
package pipeline_mem_access_pkg;
  localparam int DATA_W = 32;
  localparam logic MEM_READ = 1'b0;
  localparam logic MEM_WRITE = 1'b1;
  typedef enum logic [1:0] {
    MEMACC_IDLE  = 2'd0,
    MEMACC_WAIT  = 2'd1,
    MEMACC_DONE  = 2'd2,
    MEMACC_DRAIN = 2'd3
  } memacc_state_t;
endpackage

// File: rtl/pipeline_mem_access_if.sv
// pipeline_mem_access_if: req/ack data bus between the MEM stage and memory
interface pipeline_mem_access_if
  import pipeline_mem_access_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_W
);
  logic                  bus_req;
  logic                  bus_we;
  logic [3:0]            bus_sel;
  logic [DATA_WIDTH-1:0] bus_addr;
  logic [DATA_WIDTH-1:0] bus_wdata;
  logic [DATA_WIDTH-1:0] bus_rdata;
  logic                  bus_ack;
  modport master (
    output bus_req, bus_we, bus_sel, bus_addr, bus_wdata,
    input  bus_rdata, bus_ack
  );
  modport slave (
    input  bus_req, bus_we, bus_sel, bus_addr, bus_wdata,
    output bus_rdata, bus_ack
  );
endinterface

// File: rtl/pipeline_mem_access_bus_timeout_counter.sv
// bus_timeout_counter: counts bus wait cycles, flags the last cycle before giving up
module bus_timeout_counter #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic en,
  output logic tc
);
  localparam int W = $clog2(TIMEOUT_CYCLES + 1);
  logic [W-1:0] cnt;
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt <= '0;
    else if (clear) cnt <= '0;
    else if (en) cnt <= cnt + W'(1);
  assign tc = cnt == W'(TIMEOUT_CYCLES - 1);
endmodule

// File: rtl/pipeline_mem_access.sv
// pipeline_mem_access: runs EX/MEM load/store requests on the req/ack bus, stalling until done
module pipeline_mem_access
  import pipeline_mem_access_pkg::*;
#(
  parameter int DATA_WIDTH     = DATA_W,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  global_flush,
  input  logic                  mem_enable_in,
  input  logic                  mem_rw_in,
  input  logic [3:0]            mem_sel_in,
  input  logic [DATA_WIDTH-1:0] mem_addr_in,
  input  logic [DATA_WIDTH-1:0] mem_write_in,
  pipeline_mem_access_if.master bus,
  output logic                  stall_req,
  output logic [DATA_WIDTH-1:0] mem_read_out,
  output logic                  mem_valid_out,
  output logic                  bus_err_out
);
  memacc_state_t state, state_nx;
  logic kill, start, tc;
  assign kill  = flush | global_flush;
  assign start = !rst && state == MEMACC_IDLE && mem_enable_in && !kill;
  bus_timeout_counter #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timeout (
    .clk   (clk),
    .rst   (rst),
    .clear (start),
    .en    (state == MEMACC_WAIT || state == MEMACC_DRAIN),
    .tc    (tc)
  );
  always_comb begin
    state_nx  = state;
    stall_req = 1'b0;
    case (state)
      MEMACC_IDLE: begin
        stall_req = start;
        state_nx  = start ? MEMACC_WAIT : MEMACC_IDLE;
      end
      MEMACC_WAIT: begin
        stall_req = 1'b1;
        state_nx  = bus.bus_ack ? (kill ? MEMACC_IDLE : MEMACC_DONE) :
                    tc          ? MEMACC_DONE :
                    kill        ? MEMACC_DRAIN : MEMACC_WAIT;
      end
      MEMACC_DONE: state_nx = MEMACC_IDLE;
      MEMACC_DRAIN: begin
        // a killed transfer still owns the bus, so a new access has to wait
        stall_req = mem_enable_in;
        state_nx  = (bus.bus_ack || tc) ? MEMACC_IDLE : MEMACC_DRAIN;
      end
      default: state_nx = MEMACC_IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= MEMACC_IDLE;
    else state <= state_nx;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      bus.bus_req   <= 1'b0;
      bus.bus_we    <= 1'b0;
      bus.bus_sel   <= '0;
      bus.bus_addr  <= '0;
      bus.bus_wdata <= '0;
      mem_read_out  <= '0;
      mem_valid_out <= 1'b0;
      bus_err_out   <= 1'b0;
    end else begin
      mem_valid_out <= 1'b0;
      bus_err_out   <= 1'b0;
      if (start) begin
        bus.bus_req   <= 1'b1;
        bus.bus_we    <= mem_rw_in;
        bus.bus_sel   <= mem_sel_in;
        bus.bus_addr  <= {mem_addr_in[DATA_WIDTH-1:2], 2'b00};
        bus.bus_wdata <= mem_write_in;
      end
      if (state == MEMACC_WAIT && bus.bus_ack) begin
        bus.bus_req <= 1'b0;
        if (!kill) begin
          mem_read_out  <= bus.bus_we == MEM_WRITE ? '0 : bus.bus_rdata;
          mem_valid_out <= 1'b1;
        end
      end else if (state == MEMACC_WAIT && tc) begin
        bus.bus_req  <= 1'b0;
        bus_err_out  <= 1'b1;
        mem_read_out <= '0;
      end
      if (state == MEMACC_DRAIN && (bus.bus_ack || tc)) begin
        bus.bus_req <= 1'b0;
        bus_err_out <= !bus.bus_ack;
      end
    end
endmodule

// File: tb/tb_pipeline_mem_access.sv
// tb_pipeline_mem_access: directed and random checks against a transaction-level model
module tb_pipeline_mem_access;
  localparam int T = 8;
  logic clk = 1'b0, rst = 1'b1, flush = 1'b0, global_flush = 1'b0;
  logic mem_enable_in = 1'b0, mem_rw_in = 1'b0;
  logic [3:0] mem_sel_in = '0;
  logic [31:0] mem_addr_in = '0, mem_write_in = '0;
  logic stall_req, mem_valid_out, bus_err_out;
  logic [31:0] mem_read_out;
  int total = 0, bad = 0, stall_cnt = 0, valid_cnt = 0;
  pipeline_mem_access_if #(.DATA_WIDTH(32)) bif ();
  pipeline_mem_access #(.DATA_WIDTH(32), .TIMEOUT_CYCLES(T)) dut (
    .clk           (clk),
    .rst           (rst),
    .flush         (flush),
    .global_flush  (global_flush),
    .mem_enable_in (mem_enable_in),
    .mem_rw_in     (mem_rw_in),
    .mem_sel_in    (mem_sel_in),
    .mem_addr_in   (mem_addr_in),
    .mem_write_in  (mem_write_in),
    .bus           (bif.master),
    .stall_req     (stall_req),
    .mem_read_out  (mem_read_out),
    .mem_valid_out (mem_valid_out),
    .bus_err_out   (bus_err_out)
  );
  always #5 clk = ~clk;
  // model: is a bus transfer outstanding, was its result killed, how long has it waited
  bit m_out = 0, m_kill = 0, m_done = 0, m_we = 0, m_valid = 0, m_err = 0;
  int m_age = 0;
  logic [3:0] m_sel = '0;
  logic [31:0] m_addr = '0, m_wdata = '0, m_rd = '0;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_out = 0; m_kill = 0; m_done = 0; m_we = 0; m_valid = 0; m_err = 0;
      m_age = 0; m_sel = '0; m_addr = '0; m_wdata = '0; m_rd = '0;
    end else begin
      m_valid = 0;
      m_err = 0;
      if (m_done) m_done = 0;
      else if (!m_out) begin
        if (mem_enable_in && !(flush || global_flush)) begin
          m_out = 1; m_kill = 0; m_age = 0;
          m_we = mem_rw_in; m_sel = mem_sel_in; m_wdata = mem_write_in;
          m_addr = mem_addr_in & 32'hFFFF_FFFC;
        end
      end else if (bif.bus_ack) begin
        m_out = 0;
        if (!m_kill && !(flush || global_flush)) begin
          m_done = 1; m_valid = 1; m_rd = m_we ? 32'h0 : bif.bus_rdata;
        end
      end else if (m_age == T - 1) begin
        m_out = 0; m_err = 1;
        if (!m_kill) begin m_done = 1; m_rd = 32'h0; end
      end else begin
        if (flush || global_flush) m_kill = 1;
        m_age++;
      end
    end
  end
  function automatic logic exp_stall();
    if (rst || m_done) return 1'b0;
    if (!m_out) return mem_enable_in && !(flush || global_flush);
    return m_kill ? mem_enable_in : 1'b1;
  endfunction
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask
  always @(negedge clk) begin
    chk("stall_req", {31'b0, stall_req}, {31'b0, exp_stall()});
    chk("bus_req", {31'b0, bif.bus_req}, {31'b0, m_out});
    chk("bus_we", {31'b0, bif.bus_we}, {31'b0, m_we});
    chk("bus_sel", {28'b0, bif.bus_sel}, {28'b0, m_sel});
    chk("bus_addr", bif.bus_addr, m_addr);
    chk("bus_wdata", bif.bus_wdata, m_wdata);
    chk("mem_read_out", mem_read_out, m_rd);
    chk("mem_valid_out", {31'b0, mem_valid_out}, {31'b0, m_valid});
    chk("bus_err_out", {31'b0, bus_err_out}, {31'b0, m_err});
    if (stall_req) stall_cnt++;
    if (mem_valid_out) valid_cnt++;
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic issue(input logic rw, input logic [3:0] sel, input logic [31:0] addr, input logic [31:0] wd);
    mem_enable_in = 1'b1;
    mem_rw_in = rw;
    mem_sel_in = sel;
    mem_addr_in = addr;
    mem_write_in = wd;
  endtask
  initial begin
    bif.bus_ack = 1'b0;
    bif.bus_rdata = '0;
    repeat (2) tick();
    chk("reset_bus_req", {31'b0, bif.bus_req}, 0);
    chk("reset_stall", {31'b0, stall_req}, 0);
    chk("reset_read", mem_read_out, 0);
    chk("reset_valid", {31'b0, mem_valid_out}, 0);
    rst = 1'b0;
    tick();
    // load with three wait cycles
    issue(1'b0, 4'hF, 32'h0000_1003, 32'h0);
    stall_cnt = 0;
    tick();
    chk("load_bus_addr", bif.bus_addr, 32'h0000_1000);
    chk("load_bus_we", {31'b0, bif.bus_we}, 0);
    tick();
    tick();
    bif.bus_ack = 1'b1;
    bif.bus_rdata = 32'hDEAD_BEEF;
    tick();
    bif.bus_ack = 1'b0;
    chk("load_valid", {31'b0, mem_valid_out}, 1);
    chk("load_data", mem_read_out, 32'hDEAD_BEEF);
    chk("load_req_drop", {31'b0, bif.bus_req}, 0);
    mem_enable_in = 1'b0;
    tick();
    chk("load_stall_cycles", stall_cnt, 4);
    chk("load_valid_pulse", {31'b0, mem_valid_out}, 0);
    // reset in the middle of a transfer
    issue(1'b0, 4'hF, 32'h0000_0600, 32'h0);
    tick();
    tick();
    chk("rst_pre_req", {31'b0, bif.bus_req}, 1);
    rst = 1'b1;
    mem_enable_in = 1'b0;
    #1;
    chk("rst_async_req", {31'b0, bif.bus_req}, 0);
    chk("rst_async_read", mem_read_out, 0);
    chk("rst_async_stall", {31'b0, stall_req}, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    issue(1'b0, 4'hF, 32'h0000_0500, 32'h0);
    tick();
    chk("post_rst_req", {31'b0, bif.bus_req}, 1);
    bif.bus_ack = 1'b1;
    bif.bus_rdata = 32'hCAFE_0001;
    tick();
    bif.bus_ack = 1'b0;
    mem_enable_in = 1'b0;
    chk("post_rst_data", mem_read_out, 32'hCAFE_0001);
    tick();
    // store acked on the first wait cycle
    issue(1'b1, 4'b0011, 32'h0000_2002, 32'h0000_ABCD);
    tick();
    chk("store_we", {31'b0, bif.bus_we}, 1);
    chk("store_sel", {28'b0, bif.bus_sel}, 32'h3);
    chk("store_wdata", bif.bus_wdata, 32'h0000_ABCD);
    bif.bus_ack = 1'b1;
    bif.bus_rdata = 32'hFFFF_FFFF;
    tick();
    bif.bus_ack = 1'b0;
    mem_enable_in = 1'b0;
    chk("store_valid", {31'b0, mem_valid_out}, 1);
    chk("store_read_zero", mem_read_out, 0);
    tick();
    // flush while waiting, next load queued behind the drain
    issue(1'b0, 4'hF, 32'h0000_0100, 32'h0);
    tick();
    flush = 1'b1;
    valid_cnt = 0;
    tick();
    flush = 1'b0;
    mem_addr_in = 32'h0000_3000;
    chk("drain_req_held", {31'b0, bif.bus_req}, 1);
    repeat (4) tick();
    bif.bus_ack = 1'b1;
    bif.bus_rdata = 32'h0000_0055;
    tick();
    bif.bus_ack = 1'b0;
    chk("drain_req_drop", {31'b0, bif.bus_req}, 0);
    chk("drain_next_stall", {31'b0, stall_req}, 1);
    tick();
    chk("drain_next_req", {31'b0, bif.bus_req}, 1);
    chk("drain_next_addr", bif.bus_addr, 32'h0000_3000);
    chk("drain_no_valid", valid_cnt, 0);
    bif.bus_ack = 1'b1;
    bif.bus_rdata = 32'h0000_0077;
    tick();
    bif.bus_ack = 1'b0;
    mem_enable_in = 1'b0;
    chk("drain_next_data", mem_read_out, 32'h0000_0077);
    tick();
    // flush coincident with ack
    issue(1'b0, 4'hF, 32'h0000_0400, 32'h0);
    tick();
    flush = 1'b1;
    bif.bus_ack = 1'b1;
    bif.bus_rdata = 32'h0000_1234;
    mem_enable_in = 1'b0;
    valid_cnt = 0;
    tick();
    flush = 1'b0;
    bif.bus_ack = 1'b0;
    chk("flack_req", {31'b0, bif.bus_req}, 0);
    chk("flack_read_kept", mem_read_out, 32'h0000_0077);
    tick();
    chk("flack_no_valid", valid_cnt, 0);
    // timeout with no ack
    issue(1'b0, 4'hF, 32'h0000_0800, 32'h0);
    tick();
    for (int i = 0; i < T; i++) begin
      chk("timeout_req_held", {31'b0, bif.bus_req}, 1);
      tick();
    end
    chk("timeout_req_drop", {31'b0, bif.bus_req}, 0);
    chk("timeout_err", {31'b0, bus_err_out}, 1);
    chk("timeout_no_valid", {31'b0, mem_valid_out}, 0);
    chk("timeout_read", mem_read_out, 0);
    chk("timeout_stall_free", {31'b0, stall_req}, 0);
    mem_enable_in = 1'b0;
    tick();
    chk("timeout_err_pulse", {31'b0, bus_err_out}, 0);
    // random traffic with no-ack windows and occasional resets
    for (int i = 0; i < 3000; i++) begin
      mem_enable_in = $urandom_range(0, 9) < 7;
      mem_rw_in = 1'($urandom_range(0, 1));
      mem_sel_in = 4'($urandom);
      mem_addr_in = $urandom;
      mem_write_in = $urandom;
      flush = $urandom_range(0, 15) == 0;
      global_flush = $urandom_range(0, 31) == 0;
      bif.bus_ack = ((i / 40) % 4 == 3) ? 1'b0 : ($urandom_range(0, 2) == 0);
      bif.bus_rdata = $urandom;
      if ($urandom_range(0, 599) == 0) begin
        rst = 1'b1;
        tick();
        rst = 1'b0;
      end
      tick();
    end
    mem_enable_in = 1'b0;
    flush = 1'b0;
    global_flush = 1'b0;
    bif.bus_ack = 1'b0;
    repeat (2 * T) tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
